// File: rtl/axis_frame_sched_pkg.sv
// Shared types and defaults for the frame scheduler: FSM encoding and
// default stream/counter widths.
package axis_frame_sched_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 32;
    localparam int LEN_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/axis_frame_sched_skid.sv
// Two-entry skid buffer: r_d0 is the registered output stage, r_d1 catches
// the beat that arrives while the output is stalled.
module axis_skid_buf #(
    parameter int W = 33
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_srst,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_empty
);

    logic [W-1:0] r_d0;
    logic [W-1:0] r_d1;
    logic         r_v0;
    logic         r_v1;
    logic         w_push;
    logic         w_pop;

    assign o_ready = ~r_v1;
    assign o_data  = r_d0;
    assign o_valid = r_v0;
    assign o_empty = ~r_v0 & ~r_v1;
    assign w_push  = i_valid & ~r_v1;
    assign w_pop   = r_v0 & i_ready;

    // Buffer storage: push fills the first free slot, pop shifts the skid slot forward.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_d0 <= {W{1'b0}};
            r_d1 <= {W{1'b0}};
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
        end else if (i_srst) begin
            r_d0 <= {W{1'b0}};
            r_d1 <= {W{1'b0}};
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (!r_v0) begin
                        r_d0 <= i_data;
                        r_v0 <= 1'b1;
                    end else begin
                        r_d1 <= i_data;
                        r_v1 <= 1'b1;
                    end
                end
                2'b01: begin
                    if (r_v1) begin
                        r_d0 <= r_d1;
                        r_v1 <= 1'b0;
                    end else begin
                        r_v0 <= 1'b0;
                    end
                end
                2'b11: begin
                    if (r_v1) begin
                        r_d0 <= r_d1;
                        r_d1 <= i_data;
                    end else begin
                        r_d0 <= i_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/axis_frame_sched.sv
// Frame scheduler: each sync rising edge gates exactly one DMA-length frame
// of source beats onto the AXI-Stream master, tagging the final beat with tlast.
module axis_frame_sched
    import axis_frame_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              axiclk,
    input  logic              rst_n,
    input  logic              i_sw_rst_n,
    input  logic              i_sync_pulse,
    input  logic [LEN_W-1:0]  i_dma_len,
    input  logic [DATA_W-1:0] i_src_tdata,
    input  logic              i_src_tvalid,
    output logic              o_src_tready,
    output logic [DATA_W-1:0] o_m_axis_tdata,
    output logic              o_m_axis_tvalid,
    input  logic              i_m_axis_tready,
    output logic              o_m_axis_tlast,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [CNT_W-1:0]  o_frame_cnt,
    output logic [CNT_W-1:0]  o_miss_cnt,
    output logic              o_len_err
);

    state_e             r_state;
    logic               r_sync_q;
    logic [LEN_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_beat;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;
    logic               r_len_err;

    logic               w_srst;
    logic               w_edge;
    logic               w_buf_ready;
    logic               w_buf_empty;
    logic               w_accept;
    logic               w_last;
    logic               w_done;
    logic               w_out_valid;
    logic [DATA_W:0]    w_out_data;

    assign w_srst   = ~i_sw_rst_n;
    assign w_edge   = i_sync_pulse & ~r_sync_q;
    assign w_accept = (r_state == ST_XFER) & i_src_tvalid & w_buf_ready;
    // Beat index is compared against length-1 so the counter never has to reach the length itself.
    assign w_last   = (LEN_W'(r_beat) == (r_len - LEN_W'(1'b1)));
    assign w_done   = w_out_valid & i_m_axis_tready & w_out_data[DATA_W];

    assign o_src_tready    = (r_state == ST_XFER) & w_buf_ready;
    assign o_m_axis_tdata  = w_out_data[DATA_W-1:0];
    assign o_m_axis_tlast  = w_out_data[DATA_W];
    assign o_m_axis_tvalid = w_out_valid;
    assign o_busy          = (r_state != ST_IDLE);
    assign o_frame_done    = w_done;
    assign o_frame_cnt     = r_frame_cnt;
    assign o_miss_cnt      = r_miss_cnt;
    assign o_len_err       = r_len_err;

    axis_skid_buf #(
        .W (DATA_W + 1)
    ) u_skid (
        .i_clk   (axiclk),
        .i_rst_n (rst_n),
        .i_srst  (w_srst),
        .i_data  ({w_last, i_src_tdata}),
        .i_valid (w_accept),
        .o_ready (w_buf_ready),
        .o_data  (w_out_data),
        .o_valid (w_out_valid),
        .i_ready (i_m_axis_tready),
        .o_empty (w_buf_empty)
    );

    // Frame FSM, sync edge detect, length latch and status counters.
    always_ff @(posedge axiclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sync_q    <= 1'b0;
            r_len       <= {LEN_W{1'b0}};
            r_beat      <= {CNT_W{1'b0}};
            r_frame_cnt <= {CNT_W{1'b0}};
            r_miss_cnt  <= {CNT_W{1'b0}};
            r_len_err   <= 1'b0;
        end else if (w_srst) begin
            r_state     <= ST_IDLE;
            r_sync_q    <= 1'b0;
            r_len       <= {LEN_W{1'b0}};
            r_beat      <= {CNT_W{1'b0}};
            r_frame_cnt <= {CNT_W{1'b0}};
            r_miss_cnt  <= {CNT_W{1'b0}};
            r_len_err   <= 1'b0;
        end else begin
            r_sync_q <= i_sync_pulse;
            if (w_done) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1'b1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        if (i_dma_len != {LEN_W{1'b0}}) begin
                            r_state <= ST_XFER;
                            r_len   <= i_dma_len;
                            r_beat  <= {CNT_W{1'b0}};
                        end else begin
                            r_len_err <= 1'b1;
                        end
                    end
                end
                ST_XFER: begin
                    if (w_accept) begin
                        r_beat <= r_beat + CNT_W'(1'b1);
                        if (w_last) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                    if (w_edge) begin
                        r_miss_cnt <= r_miss_cnt + CNT_W'(1'b1);
                    end
                end
                ST_FLUSH: begin
                    if (w_buf_empty) begin
                        r_state <= ST_IDLE;
                    end
                    if (w_edge) begin
                        r_miss_cnt <= r_miss_cnt + CNT_W'(1'b1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_sched.sv
// Self-checking bench for axis_frame_sched: a queue-based frame model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_axis_frame_sched;

    localparam int DW = 32;
    localparam int CW = 32;

    logic          axiclk = 1'b0;
    logic          rst_n;
    logic          i_sw_rst_n;
    logic          i_sync_pulse;
    logic [31:0]   i_dma_len;
    logic [DW-1:0] i_src_tdata;
    logic          i_src_tvalid;
    logic          o_src_tready;
    logic [DW-1:0] o_m_axis_tdata;
    logic          o_m_axis_tvalid;
    logic          i_m_axis_tready;
    logic          o_m_axis_tlast;
    logic          o_busy;
    logic          o_frame_done;
    logic [CW-1:0] o_frame_cnt;
    logic [CW-1:0] o_miss_cnt;
    logic          o_len_err;

    always #5 axiclk = ~axiclk;

    axis_frame_sched #(.DATA_W(DW), .CNT_W(CW)) dut (
        .axiclk          (axiclk),
        .rst_n           (rst_n),
        .i_sw_rst_n      (i_sw_rst_n),
        .i_sync_pulse    (i_sync_pulse),
        .i_dma_len       (i_dma_len),
        .i_src_tdata     (i_src_tdata),
        .i_src_tvalid    (i_src_tvalid),
        .o_src_tready    (o_src_tready),
        .o_m_axis_tdata  (o_m_axis_tdata),
        .o_m_axis_tvalid (o_m_axis_tvalid),
        .i_m_axis_tready (i_m_axis_tready),
        .o_m_axis_tlast  (o_m_axis_tlast),
        .o_busy          (o_busy),
        .o_frame_done    (o_frame_done),
        .o_frame_cnt     (o_frame_cnt),
        .o_miss_cnt      (o_miss_cnt),
        .o_len_err       (o_len_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: beats accepted but not yet delivered, plus frame phase
    // (0 idle, 1 collecting, 2 draining).
    logic [DW:0] m_q[$];
    int          m_phase;
    logic [31:0] m_len;
    logic [31:0] m_cnt;
    logic [31:0] m_frames;
    logic [31:0] m_miss;
    logic        m_len_err;
    logic        m_prev_sync;

    int obs_beats, obs_lasts, obs_done, first_hs, last_hs, cyc_n;
    int src_mode, rdy_mode;
    logic rdy_tog;
    int qs, ph;
    logic edge_s, exp_done;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_phase     = 0;
        m_len       = 32'd0;
        m_cnt       = 32'd0;
        m_frames    = 32'd0;
        m_miss      = 32'd0;
        m_len_err   = 1'b0;
        m_prev_sync = 1'b0;
    endtask

    task automatic clear_obs();
        obs_beats = 0;
        obs_lasts = 0;
        obs_done  = 0;
        first_hs  = -1;
        last_hs   = -1;
    endtask

    // Compare process: check outputs against the model, then advance the model
    // with the inputs that the coming rising edge will see.
    initial begin
        forever begin
            @(negedge axiclk);
            cyc_n++;
            if (o_m_axis_tvalid && i_m_axis_tready) begin
                obs_beats++;
                if (first_hs < 0) first_hs = cyc_n;
                last_hs = cyc_n;
                if (o_m_axis_tlast) obs_lasts++;
            end
            if (o_frame_done) obs_done++;
            if (!rst_n) begin
                chk("rst_busy", o_busy, 0);
                chk("rst_tvalid", o_m_axis_tvalid, 0);
                chk("rst_tready", o_src_tready, 0);
                chk("rst_frame_cnt", o_frame_cnt, 0);
                chk("rst_miss_cnt", o_miss_cnt, 0);
                chk("rst_len_err", o_len_err, 0);
                model_reset();
            end else begin
                qs = m_q.size();
                exp_done = (qs > 0) ? (i_m_axis_tready && m_q[0][DW]) : 1'b0;
                chk("busy", o_busy, m_phase != 0);
                chk("src_tready", o_src_tready, (m_phase == 1) && (qs < 2));
                chk("tvalid", o_m_axis_tvalid, qs > 0);
                if (qs > 0) begin
                    chk("tdata", o_m_axis_tdata, m_q[0][DW-1:0]);
                    chk("tlast", o_m_axis_tlast, m_q[0][DW]);
                end
                chk("frame_done", o_frame_done, exp_done);
                chk("frame_cnt", o_frame_cnt, m_frames);
                chk("miss_cnt", o_miss_cnt, m_miss);
                chk("len_err", o_len_err, m_len_err);
                if (!i_sw_rst_n) begin
                    model_reset();
                end else begin
                    ph = m_phase;
                    edge_s = !m_prev_sync && i_sync_pulse;
                    m_prev_sync = i_sync_pulse;
                    if (qs > 0 && i_m_axis_tready) begin
                        if (m_q[0][DW]) m_frames++;
                        void'(m_q.pop_front());
                    end
                    if (ph == 1 && qs < 2 && i_src_tvalid) begin
                        m_q.push_back({(m_cnt == m_len - 32'd1), i_src_tdata});
                        m_cnt++;
                        if (m_cnt == m_len) m_phase = 2;
                    end
                    if (ph == 2 && qs == 0) m_phase = 0;
                    if (edge_s) begin
                        if (ph == 0) begin
                            if (i_dma_len != 32'd0) begin
                                m_phase = 1;
                                m_len   = i_dma_len;
                                m_cnt   = 32'd0;
                            end else begin
                                m_len_err = 1'b1;
                            end
                        end else begin
                            m_miss++;
                        end
                    end
                end
            end
        end
    end

    // Background source/sink driver, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge axiclk);
            #1;
            i_src_tdata  = $urandom;
            i_src_tvalid = (src_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            case (rdy_mode)
                0: i_m_axis_tready = 1'b1;
                1: begin rdy_tog = ~rdy_tog; i_m_axis_tready = rdy_tog; end
                default: i_m_axis_tready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge axiclk);
        #1;
    endtask

    task automatic pulse();
        i_sync_pulse = 1'b1;
        cyc(1);
        i_sync_pulse = 1'b0;
        cyc(1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (o_busy && n < budget) begin cyc(1); n++; end
        chk("idle_timeout", o_busy, 0);
        cyc(1);
    endtask

    task automatic wait_cnt(input int target, input int budget);
        int n = 0;
        while (m_cnt < target && n < budget) begin cyc(1); n++; end
        chk("cnt_timeout", n < budget, 1);
    endtask

    task automatic wait_flush(input int budget);
        int n = 0;
        while (m_phase != 2 && n < budget) begin cyc(1); n++; end
        chk("flush_timeout", n < budget, 1);
    endtask

    initial begin
        rst_n = 1'b0; i_sw_rst_n = 1'b1; i_sync_pulse = 1'b0; i_dma_len = 32'd0;
        i_src_tdata = '0; i_src_tvalid = 1'b0; i_m_axis_tready = 1'b1;
        src_mode = 0; rdy_mode = 0; rdy_tog = 1'b0; cyc_n = 0;
        model_reset();
        clear_obs();
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        chk("init_busy", o_busy, 0);
        chk("init_frames", o_frame_cnt, 0);

        // Length 4, always valid/ready: four back-to-back beats.
        clear_obs(); i_dma_len = 32'd4; pulse(); wait_idle(200);
        chk("t35_beats", obs_beats, 4);
        chk("t35_lasts", obs_lasts, 1);
        chk("t35_span", last_hs - first_hs, 3);
        chk("t35_done", obs_done, 1);
        chk("t35_frames", o_frame_cnt, 1);

        // Length 8 with toggling ready and gappy source.
        clear_obs(); src_mode = 1; rdy_mode = 1; i_dma_len = 32'd8; pulse(); wait_idle(300);
        chk("t36_beats", obs_beats, 8);
        chk("t36_lasts", obs_lasts, 1);
        chk("t36_frames", o_frame_cnt, 2);

        // Extra edge mid-frame is counted as a miss.
        clear_obs(); rdy_mode = 2; i_dma_len = 32'd16; pulse(); wait_cnt(5, 200); pulse();
        wait_idle(400);
        chk("t37_miss", o_miss_cnt, 1);
        chk("t37_beats", obs_beats, 16);
        chk("t37_frames", o_frame_cnt, 3);

        // Zero length: error flag only.
        clear_obs(); i_dma_len = 32'd0; pulse(); cyc(5);
        chk("t38_len_err", o_len_err, 1);
        chk("t38_busy", o_busy, 0);
        chk("t38_beats", obs_beats, 0);

        // Soft reset mid-frame, then a fresh length-2 frame.
        clear_obs(); src_mode = 0; rdy_mode = 0; i_dma_len = 32'd10; pulse(); wait_cnt(3, 100);
        i_sw_rst_n = 1'b0; cyc(1); i_sw_rst_n = 1'b1;
        chk("t39_busy", o_busy, 0);
        chk("t39_tvalid", o_m_axis_tvalid, 0);
        chk("t39_frames", o_frame_cnt, 0);
        chk("t39_miss", o_miss_cnt, 0);
        chk("t39_len_err", o_len_err, 0);
        chk("t39_lasts", obs_lasts, 0);
        clear_obs(); cyc(1); i_dma_len = 32'd2; pulse(); wait_idle(100);
        chk("t39_new_beats", obs_beats, 2);
        chk("t39_new_frames", o_frame_cnt, 1);

        // Length 1, length change during drain applies only to the next frame.
        clear_obs(); i_dma_len = 32'd1; pulse(); wait_flush(50); i_dma_len = 32'd5; wait_idle(100);
        chk("t40_beats1", obs_beats, 1);
        chk("t40_lasts1", obs_lasts, 1);
        clear_obs(); pulse(); wait_idle(100);
        chk("t40_beats5", obs_beats, 5);
        chk("t40_lasts5", obs_lasts, 1);
        chk("t40_frames", o_frame_cnt, 3);

        // Randomized frames with occasional extra edges and zero lengths.
        for (int i = 0; i < 40; i++) begin
            src_mode  = $urandom_range(0, 1);
            rdy_mode  = $urandom_range(0, 2);
            i_dma_len = $urandom_range(0, 12);
            pulse();
            if ($urandom_range(0, 2) == 0) begin
                cyc($urandom_range(0, 6));
                pulse();
            end
            wait_idle(500);
        end

        // Asynchronous reset mid-frame, then recovery.
        src_mode = 0; rdy_mode = 0; i_dma_len = 32'd20; pulse(); cyc(4);
        rst_n = 1'b0; #2;
        chk("arst_tvalid", o_m_axis_tvalid, 0);
        chk("arst_busy", o_busy, 0);
        cyc(1); rst_n = 1'b1; cyc(1);
        clear_obs(); i_dma_len = 32'd3; pulse(); wait_idle(100);
        chk("arst_new_beats", obs_beats, 3);
        chk("arst_new_frames", o_frame_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
